// File: rtl/mips_reg_sb_pkg.sv
// Shared defaults and clear-engine state encoding for the MIPS register file
// with busy scoreboard.
package mips_reg_sb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clear_state_t;

endpackage

// File: rtl/mips_reg_clear_fsm.sv
// Bulk-clear sequencer: walks one register index per cycle, then pulses done
// for a single cycle before returning to idle.
module mips_reg_clear_fsm
    import mips_reg_sb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_clear_req,
    output logic              o_clear_busy,
    output logic              o_clear_done,
    output logic [ADDR_W-1:0] o_idx
);

    clear_state_t      r_state;
    clear_state_t      w_next_state;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_next_idx;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
        end
    end

    // Requests arriving while a clear is already running are ignored.
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        o_clear_busy = 1'b0;
        o_clear_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_next_idx = '0;
                if (i_clear_req) begin
                    w_next_state = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                o_clear_busy = 1'b1;
                if (r_idx == {ADDR_W{1'b1}}) begin
                    w_next_state = ST_DONE;
                    w_next_idx   = '0;
                end else begin
                    w_next_idx = r_idx + 1'b1;
                end
            end
            ST_DONE: begin
                o_clear_done = 1'b1;
                w_next_state = ST_IDLE;
                w_next_idx   = '0;
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_idx   = '0;
            end
        endcase
    end

    assign o_idx = r_idx;

endmodule

// File: rtl/mips_reg_sb.sv
// MIPS register file: two combinational read ports with write bypass, two
// write ports, busy scoreboard with popcount, and a sequenced bulk clear.
module mips_reg_sb
    import mips_reg_sb_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] ReadAddr1,
    input  logic [ADDR_W-1:0] ReadAddr2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic              ReadBusy1,
    output logic              ReadBusy2,
    input  logic              WriteEn1,
    input  logic [ADDR_W-1:0] WriteAddr1,
    input  logic [DATA_W-1:0] WriteData1,
    input  logic              WriteEn2,
    input  logic [ADDR_W-1:0] WriteAddr2,
    input  logic [DATA_W-1:0] WriteData2,
    input  logic              ReserveEn,
    input  logic [ADDR_W-1:0] ReserveAddr,
    input  logic              ClearReq,
    output logic              ClearBusy,
    output logic              ClearDone,
    output logic [ADDR_W:0]   BusyCount
);

    localparam int NUM_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;

    logic                w_clear_busy;
    logic [ADDR_W-1:0]   w_clear_idx;
    logic                w_wr1;
    logic                w_wr2;
    logic                w_rsv;
    logic [ADDR_W-1:0]   w_raddr   [2];
    logic [DATA_W-1:0]   w_rd_data [2];
    logic                w_rd_busy [2];
    logic [ADDR_W:0]     w_busy_count;

    mips_reg_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .i_clk        (Clk),
        .i_reset_n    (Reset_n),
        .i_clear_req  (ClearReq),
        .o_clear_busy (w_clear_busy),
        .o_clear_done (ClearDone),
        .o_idx        (w_clear_idx)
    );

    // Updates are suppressed during a bulk clear and for r0 when it is hardwired.
    assign w_wr1 = WriteEn1 && !w_clear_busy && !((ZERO_REG != 0) && (WriteAddr1 == '0));
    assign w_wr2 = WriteEn2 && !w_clear_busy && !((ZERO_REG != 0) && (WriteAddr2 == '0));
    assign w_rsv = ReserveEn && !w_clear_busy && !((ZERO_REG != 0) && (ReserveAddr == '0));

    // Port 2 is assigned last so it wins on a shared address; a reserve beats a release.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else if (w_clear_busy) begin
            r_regs[w_clear_idx] <= '0;
            r_busy[w_clear_idx] <= 1'b0;
        end else begin
            if (w_wr1) begin
                r_regs[WriteAddr1] <= WriteData1;
                r_busy[WriteAddr1] <= 1'b0;
            end
            if (w_wr2) begin
                r_regs[WriteAddr2] <= WriteData2;
                r_busy[WriteAddr2] <= 1'b0;
            end
            if (w_rsv) begin
                r_busy[ReserveAddr] <= 1'b1;
            end
        end
    end

    assign w_raddr[0] = ReadAddr1;
    assign w_raddr[1] = ReadAddr2;

    // Forwarding uses the raw write inputs, so a write dropped during a clear is still visible.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rd_data[p] = r_regs[w_raddr[p]];
            w_rd_busy[p] = r_busy[w_raddr[p]];
            if (BYPASS != 0) begin
                if (WriteEn2 && (WriteAddr2 == w_raddr[p])) begin
                    w_rd_data[p] = WriteData2;
                end else if (WriteEn1 && (WriteAddr1 == w_raddr[p])) begin
                    w_rd_data[p] = WriteData1;
                end
                if (((WriteEn1 && (WriteAddr1 == w_raddr[p])) ||
                     (WriteEn2 && (WriteAddr2 == w_raddr[p]))) &&
                    !(ReserveEn && (ReserveAddr == w_raddr[p]))) begin
                    w_rd_busy[p] = 1'b0;
                end
            end
            if ((ZERO_REG != 0) && (w_raddr[p] == '0)) begin
                w_rd_data[p] = '0;
                w_rd_busy[p] = 1'b0;
            end
        end
    end

    always_comb begin
        w_busy_count = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_busy_count = w_busy_count + {{ADDR_W{1'b0}}, r_busy[i]};
        end
    end

    assign ReadData1 = w_rd_data[0];
    assign ReadData2 = w_rd_data[1];
    assign ReadBusy1 = w_rd_busy[0];
    assign ReadBusy2 = w_rd_busy[1];
    assign ClearBusy = w_clear_busy;
    assign BusyCount = w_busy_count;

endmodule

// File: tb/tb_mips_reg_sb.sv
// Self-checking bench for mips_reg_sb: directed vector table, clear/reset
// sequences, and randomized traffic against a behavioural model.
module tb_mips_reg_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          Clk;
    logic          Reset_n;
    logic [AW-1:0] ReadAddr1;
    logic [AW-1:0] ReadAddr2;
    logic [DW-1:0] ReadData1;
    logic [DW-1:0] ReadData2;
    logic          ReadBusy1;
    logic          ReadBusy2;
    logic          WriteEn1;
    logic [AW-1:0] WriteAddr1;
    logic [DW-1:0] WriteData1;
    logic          WriteEn2;
    logic [AW-1:0] WriteAddr2;
    logic [DW-1:0] WriteData2;
    logic          ReserveEn;
    logic [AW-1:0] ReserveAddr;
    logic          ClearReq;
    logic          ClearBusy;
    logic          ClearDone;
    logic [AW:0]   BusyCount;

    int nVectors = 0;
    int nMiss    = 0;

    logic [DW-1:0] mdlRegs [NR];
    logic          mdlBusy [NR];
    int            mdlClearPos = -1;

    typedef struct packed {
        logic          we1;
        logic [AW-1:0] wa1;
        logic [DW-1:0] wd1;
        logic          we2;
        logic [AW-1:0] wa2;
        logic [DW-1:0] wd2;
        logic          rsvEn;
        logic [AW-1:0] rsvA;
        logic [AW-1:0] ra1;
        logic [AW-1:0] ra2;
        logic [DW-1:0] expRd1;
        logic [DW-1:0] expRd2;
        logic          expBusy1;
        logic [AW:0]   expCount;
    } vec_t;

    vec_t vecs [12];

    mips_reg_sb dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .ReadAddr1   (ReadAddr1),
        .ReadAddr2   (ReadAddr2),
        .ReadData1   (ReadData1),
        .ReadData2   (ReadData2),
        .ReadBusy1   (ReadBusy1),
        .ReadBusy2   (ReadBusy2),
        .WriteEn1    (WriteEn1),
        .WriteAddr1  (WriteAddr1),
        .WriteData1  (WriteData1),
        .WriteEn2    (WriteEn2),
        .WriteAddr2  (WriteAddr2),
        .WriteData2  (WriteData2),
        .ReserveEn   (ReserveEn),
        .ReserveAddr (ReserveAddr),
        .ClearReq    (ClearReq),
        .ClearBusy   (ClearBusy),
        .ClearDone   (ClearDone),
        .BusyCount   (BusyCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [DW-1:0] expData(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (WriteEn2 && WriteAddr2 == a) return WriteData2;
        if (WriteEn1 && WriteAddr1 == a) return WriteData1;
        return mdlRegs[a];
    endfunction

    function automatic logic expBusy(input logic [AW-1:0] a);
        logic wrHit;
        if (a == 0) return 1'b0;
        wrHit = (WriteEn1 && WriteAddr1 == a) || (WriteEn2 && WriteAddr2 == a);
        if (wrHit && !(ReserveEn && ReserveAddr == a)) return 1'b0;
        return mdlBusy[a];
    endfunction

    function automatic int expCount();
        int n = 0;
        for (int i = 0; i < NR; i++) n += int'(mdlBusy[i]);
        return n;
    endfunction

    // Advance the model by one rising edge using the inputs currently driven.
    function automatic void modelEdge();
        if (!Reset_n) begin
            for (int i = 0; i < NR; i++) begin
                mdlRegs[i] = '0;
                mdlBusy[i] = 1'b0;
            end
            mdlClearPos = -1;
        end else if (mdlClearPos >= 0 && mdlClearPos < NR) begin
            mdlRegs[mdlClearPos] = '0;
            mdlBusy[mdlClearPos] = 1'b0;
            mdlClearPos++;
        end else begin
            if (WriteEn1 && WriteAddr1 != 0) begin
                mdlRegs[WriteAddr1] = WriteData1;
                mdlBusy[WriteAddr1] = 1'b0;
            end
            if (WriteEn2 && WriteAddr2 != 0) begin
                mdlRegs[WriteAddr2] = WriteData2;
                mdlBusy[WriteAddr2] = 1'b0;
            end
            if (ReserveEn && ReserveAddr != 0) mdlBusy[ReserveAddr] = 1'b1;
            if (mdlClearPos == NR) mdlClearPos = -1;
            else if (ClearReq) mdlClearPos = 0;
        end
    endfunction

    task automatic clockEdge();
        modelEdge();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic idleInputs();
        WriteEn1    = 1'b0;
        WriteAddr1  = '0;
        WriteData1  = '0;
        WriteEn2    = 1'b0;
        WriteAddr2  = '0;
        WriteData2  = '0;
        ReserveEn   = 1'b0;
        ReserveAddr = '0;
        ClearReq    = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiss++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Compare every output against the model, a little after the inputs settle.
    task automatic checkAll(input string tag);
        #1;
        checkOutput({tag, " rd1"}, ReadData1, expData(ReadAddr1));
        checkOutput({tag, " rd2"}, ReadData2, expData(ReadAddr2));
        checkOutput({tag, " busy1"}, 32'(ReadBusy1), 32'(expBusy(ReadAddr1)));
        checkOutput({tag, " busy2"}, 32'(ReadBusy2), 32'(expBusy(ReadAddr2)));
        checkOutput({tag, " count"}, 32'(BusyCount), 32'(expCount()));
        checkOutput({tag, " cbusy"}, 32'(ClearBusy), 32'(mdlClearPos >= 0 && mdlClearPos < NR));
        checkOutput({tag, " cdone"}, 32'(ClearDone), 32'(mdlClearPos == NR));
    endtask

    task automatic applyStimulus(input vec_t v);
        WriteEn1    = v.we1;
        WriteAddr1  = v.wa1;
        WriteData1  = v.wd1;
        WriteEn2    = v.we2;
        WriteAddr2  = v.wa2;
        WriteData2  = v.wd2;
        ReserveEn   = v.rsvEn;
        ReserveAddr = v.rsvA;
        ReadAddr1   = v.ra1;
        ReadAddr2   = v.ra2;
    endtask

    task automatic fillRegs();
        for (int i = 0; i < NR; i++) begin
            idleInputs();
            WriteEn1   = 1'b1;
            WriteAddr1 = AW'(i);
            WriteData1 = $urandom | 32'h1;
            clockEdge();
        end
        idleInputs();
    endtask

    task automatic checkAllZero(input string tag);
        for (int i = 0; i < NR; i += 2) begin
            ReadAddr1 = AW'(i);
            ReadAddr2 = AW'(i + 1);
            #1;
            checkOutput({tag, " rd1"}, ReadData1, 32'h0);
            checkOutput({tag, " rd2"}, ReadData2, 32'h0);
        end
        checkOutput({tag, " count"}, 32'(BusyCount), 32'h0);
    endtask

    initial begin
        int cycles;
        int dones;

        // we1 wa1 wd1 | we2 wa2 wd2 | rsv rsvA | ra1 ra2 | expRd1 expRd2 expBusy1 expCount
        vecs[0]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 5'd7, 5'd0, 32'h0,    32'h0,  1'b0, 6'd0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd7, 5'd0, 32'h0,    32'h0,  1'b1, 6'd1};
        vecs[2]  = '{1'b1, 5'd7, 32'h9,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd7, 5'd0, 32'h9,    32'h0,  1'b0, 6'd1};
        vecs[3]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd7, 5'd0, 32'h9,    32'h0,  1'b0, 6'd0};
        vecs[4]  = '{1'b1, 5'd7, 32'h11,   1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 5'd7, 5'd0, 32'h11,   32'h0,  1'b0, 6'd0};
        vecs[5]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd7, 5'd0, 32'h11,   32'h0,  1'b1, 6'd1};
        vecs[6]  = '{1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'h5555, 1'b0, 5'd0, 5'd5, 5'd7, 32'h5555, 32'h11, 1'b0, 6'd1};
        vecs[7]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd5, 5'd5, 32'h5555, 32'h5555, 1'b0, 6'd1};
        vecs[8]  = '{1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 5'd0, 5'd0, 32'h0,    32'h0,  1'b0, 6'd1};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd0, 5'd7, 32'h0,    32'h11, 1'b0, 6'd1};
        vecs[10] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 32'h22,   1'b0, 5'd0, 5'd7, 5'd7, 32'h22,   32'h22, 1'b0, 6'd1};
        vecs[11] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd7, 5'd3, 32'h22,   32'h0,  1'b0, 6'd0};

        for (int i = 0; i < NR; i++) begin
            mdlRegs[i] = '0;
            mdlBusy[i] = 1'b0;
        end
        idleInputs();
        ReadAddr1 = '0;
        ReadAddr2 = '0;
        Reset_n   = 1'b0;
        @(negedge Clk);
        clockEdge();
        clockEdge();
        Reset_n = 1'b1;
        checkAll("reset");
        checkOutput("reset cbusy", 32'(ClearBusy), 32'h0);
        checkOutput("reset cdone", 32'(ClearDone), 32'h0);

        $display("[TB] directed vector table");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d rd1", i), ReadData1, vecs[i].expRd1);
            checkOutput($sformatf("vec%0d rd2", i), ReadData2, vecs[i].expRd2);
            checkOutput($sformatf("vec%0d busy1", i), 32'(ReadBusy1), 32'(vecs[i].expBusy1));
            checkOutput($sformatf("vec%0d count", i), 32'(BusyCount), 32'(vecs[i].expCount));
            clockEdge();
        end
        idleInputs();

        $display("[TB] write all registers on port 1, read back in pairs");
        for (int i = 0; i < NR; i++) begin
            WriteEn1   = 1'b1;
            WriteAddr1 = AW'(i);
            WriteData1 = 32'(i + 1);
            clockEdge();
        end
        idleInputs();
        for (int i = 0; i < NR / 2; i++) begin
            ReadAddr1 = AW'(i);
            ReadAddr2 = AW'(NR - 1 - i);
            #1;
            checkOutput($sformatf("fill r%0d", i), ReadData1, (i == 0) ? 32'h0 : 32'(i + 1));
            checkOutput($sformatf("fill r%0d", NR - 1 - i), ReadData2, 32'(NR - i));
        end

        $display("[TB] bulk clear with reserve and a dropped write");
        fillRegs();
        ReserveEn   = 1'b1;
        ReserveAddr = 5'd3;
        clockEdge();
        idleInputs();
        ClearReq = 1'b1;
        checkAll("clrreq");
        clockEdge();
        ClearReq = 1'b0;
        cycles = 0;
        dones  = 0;
        while (ClearBusy === 1'b1 && cycles < 100) begin
            if (ClearDone === 1'b1) dones++;
            if (cycles == 10) begin
                WriteEn1   = 1'b1;
                WriteAddr1 = 5'd4;
                WriteData1 = 32'hDEAD;
                ReadAddr1  = 5'd4;
                ClearReq   = 1'b1;
            end
            checkAll("clearing");
            if (cycles == 10) checkOutput("clear bypass", ReadData1, 32'hDEAD);
            clockEdge();
            idleInputs();
            cycles++;
        end
        checkOutput("clear cycles", 32'(cycles), 32'd32);
        for (int i = 0; i < 3; i++) begin
            if (i == 0) checkOutput("clear done pulse", 32'(ClearDone), 32'h1);
            if (ClearDone === 1'b1) dones++;
            checkAll("postclear");
            clockEdge();
        end
        checkOutput("clear done count", 32'(dones), 32'h1);
        checkAllZero("cleared");

        $display("[TB] reset in the middle of a clear");
        fillRegs();
        ClearReq = 1'b1;
        clockEdge();
        ClearReq = 1'b0;
        for (int i = 0; i < 10; i++) clockEdge();
        Reset_n = 1'b0;
        clockEdge();
        Reset_n = 1'b1;
        #1;
        checkOutput("midreset cbusy", 32'(ClearBusy), 32'h0);
        checkOutput("midreset cdone", 32'(ClearDone), 32'h0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (ClearDone === 1'b1) dones++;
            clockEdge();
        end
        checkOutput("midreset no done", 32'(dones), 32'h0);
        checkAllZero("midreset");

        $display("[TB] randomized traffic");
        for (int n = 0; n < 600; n++) begin
            Reset_n     = ($urandom_range(0, 99) != 0);
            WriteEn1    = $urandom_range(0, 1) == 1;
            WriteAddr1  = AW'($urandom_range(0, 7));
            WriteData1  = $urandom;
            WriteEn2    = $urandom_range(0, 2) == 0;
            WriteAddr2  = AW'($urandom_range(0, 7));
            WriteData2  = $urandom;
            ReserveEn   = $urandom_range(0, 1) == 1;
            ReserveAddr = AW'($urandom_range(0, 7));
            ClearReq    = ($urandom_range(0, 59) == 0);
            ReadAddr1   = AW'($urandom_range(0, 7));
            ReadAddr2   = AW'($urandom_range(0, 31));
            checkAll("random");
            clockEdge();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
        $finish;
    end

endmodule
